// File: rtl/ram_readback_checker.sv
// Write-then-read self-check sequencer for a dual-port RAM controller: pulses
// start_w/start_r, checksums both read ports over DEPTH samples and reports pass/fail.
module ram_readback_checker #(
  parameter int DW      = 16,
  parameter int DEPTH   = 32,
  parameter int RD_LAT  = 2,
  parameter int GAP_CYC = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  output logic          start_w,
  output logic          start_r,
  input  logic          done_w,
  input  logic          done_r,
  input  logic [DW-1:0] douta,
  input  logic [DW-1:0] doutb,
  output logic          busy,
  output logic          result_vld,
  output logic          pass,
  output logic          timeout_err,
  output logic [15:0]   mismatch_cnt,
  output logic [DW-1:0] sum_a,
  output logic [DW-1:0] sum_b
);

  typedef enum logic [2:0] {
    S_IDLE, S_W_WAIT, S_GAP, S_LAT, S_SAMPLE, S_WAIT_R, S_REPORT
  } state_t;

  localparam int              TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT);
  localparam logic [15:0]     GAP_LAST = 16'(GAP_CYC - 1);
  localparam logic [15:0]     LAT_LAST = 16'(RD_LAT);
  localparam logic [15:0]     SMP_LAST = 16'(DEPTH - 1);

  state_t        r_state;
  logic [15:0]   r_cnt;
  logic [TW-1:0] r_tmo;
  logic          r_dr;
  logic          r_start_w;
  logic          r_start_r;
  logic          r_busy;
  logic          r_vld;
  logic          r_pass;
  logic          r_tmo_err;
  logic [15:0]   r_mis;
  logic [DW-1:0] r_sum_a;
  logic [DW-1:0] r_sum_b;

  logic [15:0]   w_mis_nxt;
  logic          w_dr_seen;

  assign w_mis_nxt = ((douta != doutb) && (r_mis != 16'hFFFF)) ? r_mis + 16'd1 : r_mis;
  assign w_dr_seen = r_dr | done_r;

  assign start_w      = r_start_w;
  assign start_r      = r_start_r;
  assign busy         = r_busy;
  assign result_vld   = r_vld;
  assign pass         = r_pass;
  assign timeout_err  = r_tmo_err;
  assign mismatch_cnt = r_mis;
  assign sum_a        = r_sum_a;
  assign sum_b        = r_sum_b;

  // result_vld is raised on entry to S_REPORT, so the REPORT cycle is the strobe cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_tmo     <= '0;
      r_dr      <= 1'b0;
      r_start_w <= 1'b0;
      r_start_r <= 1'b0;
      r_busy    <= 1'b0;
      r_vld     <= 1'b0;
      r_pass    <= 1'b0;
      r_tmo_err <= 1'b0;
      r_mis     <= '0;
      r_sum_a   <= '0;
      r_sum_b   <= '0;
    end else begin
      r_start_w <= 1'b0;
      r_start_r <= 1'b0;
      r_vld     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_mis     <= '0;
            r_sum_a   <= '0;
            r_sum_b   <= '0;
            r_pass    <= 1'b0;
            r_tmo_err <= 1'b0;
            r_dr      <= 1'b0;
            r_tmo     <= '0;
            r_start_w <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_W_WAIT;
          end
        end
        S_W_WAIT: begin
          if (done_w) begin
            r_cnt <= '0;
            if (GAP_CYC == 0) begin
              r_start_r <= 1'b1;
              r_state   <= S_LAT;
            end else begin
              r_state <= S_GAP;
            end
          end else if (r_tmo == TMO_LAST) begin
            r_tmo_err <= 1'b1;
            r_pass    <= 1'b0;
            r_busy    <= 1'b0;
            r_vld     <= 1'b1;
            r_state   <= S_REPORT;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt     <= '0;
            r_start_r <= 1'b1;
            r_state   <= S_LAT;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_LAT: begin
          if (done_r) r_dr <= 1'b1;
          if (r_cnt == LAT_LAST) begin
            r_cnt   <= '0;
            r_state <= S_SAMPLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        // An early done_r lets the last sample go straight to the report cycle
        S_SAMPLE: begin
          r_sum_a <= r_sum_a + douta;
          r_sum_b <= r_sum_b + doutb;
          r_mis   <= w_mis_nxt;
          if (done_r) r_dr <= 1'b1;
          if (r_cnt == SMP_LAST) begin
            r_cnt <= '0;
            if (w_dr_seen) begin
              r_pass  <= (w_mis_nxt == 16'd0);
              r_busy  <= 1'b0;
              r_vld   <= 1'b1;
              r_state <= S_REPORT;
            end else begin
              r_tmo   <= '0;
              r_state <= S_WAIT_R;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_WAIT_R: begin
          if (w_dr_seen) begin
            r_dr    <= 1'b1;
            r_pass  <= (r_mis == 16'd0);
            r_busy  <= 1'b0;
            r_vld   <= 1'b1;
            r_state <= S_REPORT;
          end else if (r_tmo == TMO_LAST) begin
            r_tmo_err <= 1'b1;
            r_pass    <= 1'b0;
            r_busy    <= 1'b0;
            r_vld     <= 1'b1;
            r_state   <= S_REPORT;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_REPORT: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_readback_checker.sv
// Bench for ram_readback_checker: a cycle-level controller model feeds read data
// and done pulses; expected timing, sums and verdicts come from a reference model.
module tb_ram_readback_checker;
  localparam int DW      = 16;
  localparam int DEPTH   = 32;
  localparam int RD_LAT  = 2;
  localparam int GAP_CYC = 4;
  localparam int TIMEOUT = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          go = 1'b0;
  logic          done_w = 1'b0;
  logic          done_r = 1'b0;
  logic [DW-1:0] douta = '0;
  logic [DW-1:0] doutb = '0;
  logic          start_w, start_r, busy, result_vld, pass, timeout_err;
  logic [15:0]   mismatch_cnt;
  logic [DW-1:0] sum_a, sum_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] da[DEPTH];
  logic [DW-1:0] db[DEPTH];

  typedef struct {
    int dmode;
    int wdly;
    int droff;
    int go2;
    bit exp_pass;
    bit exp_tmo;
  } vec_t;

  always #5 clk = ~clk;

  ram_readback_checker #(
    .DW(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .go(go),
    .start_w(start_w), .start_r(start_r),
    .done_w(done_w), .done_r(done_r),
    .douta(douta), .doutb(doutb),
    .busy(busy), .result_vld(result_vld), .pass(pass), .timeout_err(timeout_err),
    .mismatch_cnt(mismatch_cnt), .sum_a(sum_a), .sum_b(sum_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 0: address pattern, 1: address with bit0 flipped on port B at 5 and 17,
  // 2: random equal data, 3: random data with random single-bit flips on port B
  task automatic fill(input int dmode);
    for (int k = 0; k < DEPTH; k++) begin
      case (dmode)
        0: begin da[k] = DW'(k); db[k] = DW'(k); end
        1: begin
          da[k] = DW'(k);
          db[k] = (k == 5 || k == 17) ? (DW'(k) ^ DW'(1)) : DW'(k);
        end
        2: begin da[k] = DW'($urandom); db[k] = da[k]; end
        default: begin
          da[k] = DW'($urandom);
          db[k] = da[k];
          if ($urandom_range(0, 3) == 0) db[k] = da[k] ^ (DW'(1) << $urandom_range(0, DW - 1));
        end
      endcase
    end
  endtask

  // Reference expectations from the test's timing rules and data arrays
  task automatic model(input int wdly, input int droff, output int e_sr, output int e_rv,
                       output bit e_tmo, output logic [15:0] e_mis,
                       output logic [DW-1:0] e_sa, output logic [DW-1:0] e_sb);
    int fs, e_last, sa, sb, mis;
    e_sr = -1; e_tmo = 0; sa = 0; sb = 0; mis = 0;
    if (wdly < 0) begin
      e_tmo = 1;
      e_rv  = 1 + TIMEOUT + 1;
    end else begin
      e_sr   = 1 + wdly + GAP_CYC + 1;
      fs     = e_sr + RD_LAT + 1;
      e_last = fs + DEPTH - 1;
      for (int k = 0; k < DEPTH; k++) begin
        sa += int'(da[k]);
        sb += int'(db[k]);
        if (da[k] != db[k]) mis++;
      end
      if (droff < 0) begin
        e_tmo = 1;
        e_rv  = e_last + 1 + TIMEOUT + 1;
      end else if (e_sr + droff <= e_last) begin
        e_rv = e_last + 1;
      end else begin
        e_rv = e_sr + droff + 1;
      end
    end
    e_sa  = DW'(sa);
    e_sb  = DW'(sb);
    e_mis = (mis > 65535) ? 16'hFFFF : 16'(mis);
  endtask

  // Run one test from go; t counts cycles after the go-sampling edge
  task automatic run_test(input string tag, input int wdly, input int droff, input int go2,
                          input bit exp_pass, input bit exp_tmo);
    int t, t_sw, t_sr, t_rv, n_sw, n_sr, n_rv, k;
    int e_sr, e_rv;
    bit e_tmo;
    logic [15:0] e_mis, c_mis;
    logic [DW-1:0] e_sa, e_sb, c_sa, c_sb, h_sa;
    logic c_pass, c_tmo, c_busy, h_pass, h_tmo;
    t = 0; t_sw = -1; t_sr = -1; t_rv = -1; n_sw = 0; n_sr = 0; n_rv = 0;
    c_mis = 'x; c_sa = 'x; c_sb = 'x; c_pass = 1'bx; c_tmo = 1'bx; c_busy = 1'bx;
    h_sa = 'x; h_pass = 1'bx; h_tmo = 1'bx;
    model(wdly, droff, e_sr, e_rv, e_tmo, e_mis, e_sa, e_sb);
    go = 1'b1;
    while (t < 3000) begin
      tick();
      t++;
      go     = (go2 >= 0 && t == go2);
      done_w = 1'b0;
      done_r = 1'b0;
      douta  = DW'($urandom);
      doutb  = DW'($urandom);
      if (start_w) begin n_sw++; if (t_sw < 0) t_sw = t; end
      if (start_r) begin n_sr++; if (t_sr < 0) t_sr = t; end
      if (result_vld) begin
        n_rv++; t_rv = t;
        c_pass = pass; c_tmo = timeout_err; c_mis = mismatch_cnt;
        c_sa = sum_a; c_sb = sum_b; c_busy = busy;
      end
      if (t_rv >= 0 && t == t_rv + 3) begin
        h_pass = pass; h_tmo = timeout_err; h_sa = sum_a;
      end
      if (t_sw >= 0 && wdly >= 0 && t == t_sw + wdly) done_w = 1'b1;
      if (t_sr >= 0) begin
        k = t - (t_sr + RD_LAT + 1);
        if (k >= 0 && k < DEPTH) begin douta = da[k]; doutb = db[k]; end
        if (droff >= 0 && t == t_sr + droff) done_r = 1'b1;
      end
      if (t_rv >= 0 && t >= t_rv + 5) break;
    end
    go = 1'b0;
    check({tag, " start_w cycle"}, 64'(t_sw), 64'(1));
    check({tag, " start_w count"}, 64'(n_sw), 64'(1));
    check({tag, " start_r count"}, 64'(n_sr), (wdly < 0) ? 64'(0) : 64'(1));
    if (wdly >= 0) check({tag, " start_r cycle"}, 64'(t_sr), 64'(e_sr));
    check({tag, " result_vld count"}, 64'(n_rv), 64'(1));
    check({tag, " result_vld cycle"}, 64'(t_rv), 64'(e_rv));
    check({tag, " pass"}, 64'(c_pass), 64'(exp_pass));
    check({tag, " timeout_err"}, 64'(c_tmo), 64'(exp_tmo));
    check({tag, " mismatch_cnt"}, 64'(c_mis), 64'(e_mis));
    check({tag, " sum_a"}, 64'(c_sa), 64'(e_sa));
    check({tag, " sum_b"}, 64'(c_sb), 64'(e_sb));
    check({tag, " busy at result"}, 64'(c_busy), 64'(0));
    check({tag, " pass held"}, 64'(h_pass), 64'(exp_pass));
    check({tag, " timeout held"}, 64'(h_tmo), 64'(exp_tmo));
    check({tag, " sum_a held"}, 64'(h_sa), 64'(e_sa));
  endtask

  initial begin
    vec_t vecs[9];
    int n_sr_after, n_sw_after, busy_after;
    int wd, dro, e_sr0, e_rv0;
    bit e_tmo0;
    logic [15:0] e_mis0;
    logic [DW-1:0] e_sa0, e_sb0;

    // dmode, wdly, droff, go2, pass, timeout
    vecs[0] = '{0, 3, RD_LAT + 1 + DEPTH, -1, 1'b1, 1'b0};  // nominal, done_r after last sample
    vecs[1] = '{1, 3, RD_LAT + 1 + DEPTH, -1, 1'b0, 1'b0};  // two flipped samples
    vecs[2] = '{0, 3, 10, -1, 1'b1, 1'b0};                  // done_r during SAMPLE
    vecs[3] = '{2, 2, 0, -1, 1'b1, 1'b0};                   // done_r with start_r
    vecs[4] = '{2, 0, 40, -1, 1'b1, 1'b0};                  // done_w with start_w
    vecs[5] = '{0, 3, 36, 20, 1'b1, 1'b0};                  // go mid-SAMPLE ignored
    vecs[6] = '{2, 5, RD_LAT + DEPTH, -1, 1'b1, 1'b0};      // done_r on last sample
    vecs[7] = '{0, 3, -1, -1, 1'b0, 1'b1};                  // done_r never
    vecs[8] = '{0, -1, -1, -1, 1'b0, 1'b1};                 // done_w never

    repeat (3) tick();
    check("reset start_w", 64'(start_w), 64'(0));
    check("reset start_r", 64'(start_r), 64'(0));
    check("reset busy", 64'(busy), 64'(0));
    check("reset result_vld", 64'(result_vld), 64'(0));
    check("reset pass", 64'(pass), 64'(0));
    check("reset mismatch_cnt", 64'(mismatch_cnt), 64'(0));
    check("reset sum_a", 64'(sum_a), 64'(0));
    rst = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 9; i++) begin
      fill(vecs[i].dmode);
      run_test($sformatf("vec%0d", i), vecs[i].wdly, vecs[i].droff, vecs[i].go2,
               vecs[i].exp_pass, vecs[i].exp_tmo);
      tick();
    end

    // Randomized runs: verdict comes from the reference model
    for (int r = 0; r < 8; r++) begin
      fill(($urandom_range(0, 1) == 0) ? 2 : 3);
      wd  = $urandom_range(0, 20);
      dro = $urandom_range(0, 60);
      model(wd, dro, e_sr0, e_rv0, e_tmo0, e_mis0, e_sa0, e_sb0);
      run_test($sformatf("rand%0d", r), wd, dro, -1, (e_mis0 == 16'd0) && !e_tmo0, e_tmo0);
      tick();
    end

    // Nominal run leaves non-zero sums so the reset clearing is observable
    fill(0);
    run_test("pre-reset", 3, RD_LAT + 1 + DEPTH, -1, 1'b1, 1'b0);
    tick();
    go = 1'b1;
    tick();
    go = 1'b0;
    check("rst seq start_w", 64'(start_w), 64'(1));
    done_w = 1'b1;
    tick();
    done_w = 1'b0;
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    check("async rst busy", 64'(busy), 64'(0));
    check("async rst start_r", 64'(start_r), 64'(0));
    check("async rst sum_a", 64'(sum_a), 64'(0));
    check("async rst sum_b", 64'(sum_b), 64'(0));
    check("async rst mismatch_cnt", 64'(mismatch_cnt), 64'(0));
    #9 rst = 1'b1;
    n_sr_after = 0; n_sw_after = 0; busy_after = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (start_r) n_sr_after++;
      if (start_w) n_sw_after++;
      if (busy) busy_after++;
    end
    check("post-rst start_r pulses", 64'(n_sr_after), 64'(0));
    check("post-rst start_w pulses", 64'(n_sw_after), 64'(0));
    check("post-rst busy cycles", 64'(busy_after), 64'(0));
    fill(0);
    run_test("post-reset", 3, RD_LAT + 1 + DEPTH, -1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_readback_checker.md
Name: ram_readback_checker

Overview:
- Sequencer and checker that drives the true dual-port RAM controller's start_w/start_r pulses and consumes its douta/doutb read streams and done handshakes.
- Runs one write-then-read test per go pulse, accumulating per-port 16-bit checksums and counting cycles where the two read ports disagree.
- Reports pass/fail with a one-cycle result strobe. Serves as the self-check stage directly downstream of the controller.

Parameters:
- DW, 16, width of douta/doutb and checksums
- DEPTH, 32, read samples per test (1..65535)
- RD_LAT, 2, cycles from start_r pulse to first valid sample (0..255)
- GAP_CYC, 4, idle cycles between done_w and start_r (0..255)
- TIMEOUT, 1024, maximum cycles spent waiting for done_w or done_r

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- go  input  1  single-cycle request to start a test
- start_w  output  1  one-cycle write-start pulse to controller
- start_r  output  1  one-cycle read-start pulse to controller
- done_w  input  1  controller write-complete pulse
- done_r  input  1  controller read-complete pulse
- douta  input  DW  controller port-A read data
- doutb  input  DW  controller port-B read data
- busy  output  1  high from go acceptance until result_vld
- result_vld  output  1  one-cycle strobe; pass/fail/counters valid
- pass  output  1  test passed (held until next go)
- timeout_err  output  1  done_w or done_r wait exceeded TIMEOUT (held)
- mismatch_cnt  output  16  samples where douta != doutb (saturates at 16'hFFFF)
- sum_a  output  DW  modulo-2^DW sum of port-A samples
- sum_b  output  DW  modulo-2^DW sum of port-B samples

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; counters and accumulators 0.
- IDLE: go=1 → clear mismatch_cnt, sum_a, sum_b, pass, timeout_err, and the done_r latch; assert start_w for exactly the next cycle; busy=1; enter W_WAIT.
- W_WAIT: done_w=1 → GAP. Waiting TIMEOUT cycles without done_w → REPORT with timeout_err=1.
- GAP: count GAP_CYC cycles. Then start_r=1 for one cycle and enter LAT.
- LAT: count RD_LAT cycles after the start_r cycle. RD_LAT=0 → first sample taken in the cycle immediately after start_r.
- SAMPLE: exactly DEPTH consecutive cycles. Each cycle: sum_a+=douta, sum_b+=doutb (wrap); if douta != doutb, increment mismatch_cnt (saturating). Then WAIT_R.
- done_r latch: set on any done_r=1 from the start_r cycle onward; cleared only on go acceptance.
- WAIT_R: latch already set (including done_r arriving during LAT/SAMPLE) → REPORT next cycle. Otherwise wait for done_r, with TIMEOUT counted from WAIT_R entry → REPORT with timeout_err=1.
- REPORT: result_vld=1 for one cycle; pass = (mismatch_cnt==0) && !timeout_err; busy drops the same cycle; return to IDLE.
- Retained outputs: pass, timeout_err, mismatch_cnt, sum_a, sum_b keep their values in IDLE until the next accepted go.
- go while busy=1 is ignored; no queuing.
- done_w outside W_WAIT is ignored.
- Timeout path: skips any remaining states. Sums and counters hold their partial values.
- rst assertion mid-test: immediate return to IDLE with all outputs 0; no pending start pulse is emitted after release.
- Latency, nominal run: go→start_w 1 cycle; done_w→start_r GAP_CYC+1 cycles; start_r→first sample RD_LAT+1 cycles.

Test Plan:
- Nominal: DEPTH=32, RD_LAT=2, controller model returns douta=doutb=addr (0..31), done_r after last sample → result_vld once; pass=1; mismatch_cnt=0; sum_a=sum_b=16'd496.
- Mismatch: same run, model flips doutb bit0 at addresses 5 and 17 → mismatch_cnt=2; pass=0; sum_a=496; sum_b=496 ± per-flip delta as computed.
- Timeout: done_w never asserted, TIMEOUT=1024 → start_r never pulses; result_vld 1025 cycles after start_w; timeout_err=1; pass=0.
- Early done_r: done_r pulses during SAMPLE → all DEPTH samples still taken; result_vld the cycle after SAMPLE ends; pass=1.
- go while busy: second go mid-SAMPLE → exactly one start_w and one start_r per test; single result_vld.
- Async reset mid-run: rst=0 for 10 ns during GAP → busy, start_r, and counters 0 immediately; no start_r after release; new go runs a clean pass.
